// File: rtl/timeslot_arbiter.sv
// Two-requester time-slot arbiter: fixed-length slots separated by a one-cycle gap,
// round-robin on contention, shared registered datapath.
module timeslot_arbiter #(
  parameter logic [15:0] SLOT_LEN = 16'd8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req,
  input  logic [15:0] data0,
  input  logic [15:0] data1,
  output logic [1:0]  gnt,
  output logic [15:0] out,
  output logic [15:0] slot_timer,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SLOT0 = 2'd1,
    SLOT1 = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_gnt;
  logic [1:0]  w_gnt_nxt;
  logic [15:0] r_out;
  logic [15:0] w_out_nxt;
  logic [15:0] r_timer;
  logic [15:0] w_timer_nxt;
  logic        r_last;
  logic        w_last_nxt;
  logic        w_enter;
  logic        w_win;
  logic        w_other;

  assign w_other = ~r_last;

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_out_nxt   = r_out;
    w_timer_nxt = r_timer;
    w_last_nxt  = r_last;
    w_enter     = 1'b0;
    w_win       = 1'b0;

    case (r_state)
      IDLE: begin
        w_gnt_nxt   = '0;
        w_out_nxt   = '0;
        w_timer_nxt = '0;
        case (req)
          2'b01:   begin w_enter = 1'b1; w_win = 1'b0;    end
          2'b10:   begin w_enter = 1'b1; w_win = 1'b1;    end
          2'b11:   begin w_enter = 1'b1; w_win = w_other; end
          default: ;
        endcase
      end
      SLOT0, SLOT1: begin
        w_out_nxt = (r_state == SLOT1) ? data1 : data0;
        if (r_timer != 16'd0) begin
          w_timer_nxt = r_timer - 16'd1;
        end else begin
          w_state_nxt = GAP;
          w_gnt_nxt   = '0;
          w_out_nxt   = '0;
          w_timer_nxt = '0;
        end
      end
      GAP: begin
        w_gnt_nxt   = '0;
        w_out_nxt   = '0;
        w_timer_nxt = '0;
        if (req[w_other]) begin
          w_enter = 1'b1;
          w_win   = w_other;
        end else if (req[r_last]) begin
          w_enter = 1'b1;
          w_win   = r_last;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = '0;
        w_out_nxt   = '0;
        w_timer_nxt = '0;
      end
    endcase

    // Slot entry overrides the per-state defaults above; out starts at 0 so the
    // first slot cycle never shows stale or foreign data.
    if (w_enter) begin
      w_state_nxt = w_win ? SLOT1 : SLOT0;
      w_gnt_nxt   = w_win ? 2'b10 : 2'b01;
      w_out_nxt   = '0;
      w_timer_nxt = SLOT_LEN - 16'd1;
      w_last_nxt  = w_win;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_out   <= '0;
      r_timer <= '0;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_out   <= w_out_nxt;
      r_timer <= w_timer_nxt;
      r_last  <= w_last_nxt;
    end
  end

  assign gnt        = r_gnt;
  assign out        = r_out;
  assign slot_timer = r_timer;
  assign busy       = (r_state != IDLE);

endmodule

// File: doc/timeslot_arbiter.md
TIMESLOT_ARBITER -- requirements
Module: timeslot_arbiter

Interface
REQ-001 SHALL have parameter SLOT_LEN, default 16'd8, slot length in cycles (legal range 1..65535).
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req  input  2  per-requester request, bit i = requester i.
REQ-005 SHALL have port data0  input  16  requester 0 payload.
REQ-006 SHALL have port data1  input  16  requester 1 payload.
REQ-007 SHALL have port gnt  output  2  registered grant, one-hot or zero.
REQ-008 SHALL have port out  output  16  registered shared-datapath output.
REQ-009 SHALL have port slot_timer  output  16  registered remaining cycles in current slot.
REQ-010 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-011 SHALL implement four states: IDLE, SLOT0, SLOT1, GAP.
REQ-012 SHALL keep a last-granted pointer `last`, updated on each slot entry.
REQ-013 IDLE, req==00: stay IDLE; gnt=00, out=0, slot_timer=0.
REQ-014 IDLE, exactly one req bit set: enter that requester's slot next cycle.
REQ-015 IDLE, req==11: enter the slot of the requester != last (round-robin).
REQ-016 Slot entry: load slot_timer with SLOT_LEN-1; set gnt one-hot to the winner; set last to the winner.
REQ-017 SLOTx: gnt[x]=1 for exactly SLOT_LEN consecutive cycles, independent of req (no early release, no extension).
REQ-018 SLOTx, each cycle: out <= datax sampled at that edge, giving one-cycle latency from datax to out.
REQ-019 SLOTx, slot_timer!=0: decrement slot_timer by 1.
REQ-020 SLOTx, slot_timer==0: go to GAP; slot_timer holds 0; no wrap to 16'hFFFF.
REQ-021 GAP: lasts exactly one cycle; gnt=00; out=0.
REQ-022 GAP exit: if req[other] set, enter SLOT(other).
REQ-023 GAP exit: else if req[last] set, enter SLOT(last).
REQ-024 GAP exit: else go to IDLE.
REQ-025 Requests are sampled only in IDLE and GAP; req changes during a slot SHALL have no effect on gnt, out or slot_timer.
REQ-026 out SHALL never carry data from a non-granted requester; out is 0 whenever gnt==00.
REQ-027 SLOT_LEN==1: each slot lasts 1 cycle, with slot_timer==0 throughout.
REQ-028 gnt==11 SHALL never occur.

Reset
REQ-029 rst_n low SHALL immediately, without waiting for clk, force: state=IDLE, gnt=00, out=0, slot_timer=0, busy=0, last=1.
REQ-030 Reset asserted mid-slot SHALL abort the slot; no GAP cycle is issued.
REQ-031 After rst_n deasserts, the first grant with req==11 SHALL go to requester 0.

Verification
REQ-032 Reset, then req=01 held, data0=16'h00AA, SLOT_LEN=8 -> gnt=01 for 8 cycles; slot_timer 7..0; out=00AA from the second slot cycle; 1 GAP cycle; slot re-entered.
REQ-033 req=11 held from reset -> alternating SLOT0 (8 cycles), GAP, SLOT1 (8 cycles), GAP, SLOT0; gnt never 11.
REQ-034 req=10 for one cycle only, then 00 -> SLOT1 lasts a full 8 cycles, then GAP, then IDLE with busy=0.
REQ-035 rst_n pulsed low at slot_timer=3 during SLOT1 -> outputs 0 asynchronously; next req=11 grants requester 0.
REQ-036 SLOT_LEN=1, req=11 -> pattern SLOT0, GAP, SLOT1, GAP repeating; slot_timer constantly 0.
REQ-037 data1 toggled every cycle during SLOT0 -> out stays equal to data0 delayed by one cycle; never shows a data1 value.
